uart_packet_dispatcher: RTL and testbench

Receive-side packet controller between the UART byte receiver and the addressed peripheral controllers (power potentiometers, comparator/op-amp potentiometers, ADCs, GPIO).
- Parses the host frame: prefix 0xEE, dest address, length, payload, CRC.
- Streams payload bytes to the addressed destination with a one-cycle valid strobe.
- Validates CRC, recovers from inter-byte timeouts, and reports packet start, end and error events.

---
 rtl/uart_packet_dispatcher.sv | 148 ++++++++++++++
 tb/tb_uart_packet_dispatcher.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_dispatcher.sv
// uart_packet_dispatcher: parses EE/addr/len/payload/crc frames from the UART
// ports: clk,n_rst | rx_data,rx_valid in | addr,data,data_valid,pkt_* ,busy out
module uart_packet_dispatcher #(
  parameter logic [7:0] PREFIX       = 8'hEE,
  parameter bit         CHECK_CRC    = 1'b0,
  parameter int         TIMEOUT_CLKS = 1000000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] addr,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       pkt_start,
  output logic       pkt_end,
  output logic       pkt_err,
  output logic       busy
);

  localparam int CW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CRC
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    crc_q, crc_d;
  logic [7:0]    rem_q, rem_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          start_q, start_d;
  logic          end_q, end_d;
  logic          err_q, err_d;
  logic          timeout;

  // a byte landing on the timeout clock is dropped
  assign timeout = (state_q != S_IDLE) && (tmo_q == TO_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      crc_q   <= '0;
      rem_q   <= '0;
      drop_q  <= 1'b0;
      tmo_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      rem_q   <= rem_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      start_q <= start_d;
      end_q   <= end_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        S_IDLE:  if (rx_data == PREFIX) state_d = S_ADDR;
        S_ADDR:  state_d = S_LEN;
        S_LEN:   state_d = (rx_data == 8'h00) ? S_CRC : S_DATA;
        S_DATA:  if (rem_q == 8'h01) state_d = S_CRC;
        S_CRC:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    crc_d   = crc_q;
    rem_d   = rem_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    start_d = 1'b0;
    end_d   = 1'b0;
    err_d   = 1'b0;
    if (rx_valid || state_q == S_IDLE || state_d != state_q) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + CW'(1);
    end
    if (timeout) begin
      err_d = 1'b1;
    end else if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data == PREFIX) crc_d = '0;
        end
        S_ADDR: begin
          crc_d  = crc_q ^ rx_data;
          drop_d = rx_data[7];
          if (!rx_data[7]) addr_d = rx_data[6:0];
        end
        S_LEN: begin
          crc_d   = crc_q ^ rx_data;
          rem_d   = rx_data;
          start_d = !drop_q;
        end
        S_DATA: begin
          crc_d = crc_q ^ rx_data;
          rem_d = rem_q - 8'h01;
          if (!drop_q) begin
            data_d = rx_data;
            dv_d   = 1'b1;
          end
        end
        S_CRC: begin
          if (drop_q || (CHECK_CRC && rx_data != crc_q)) begin
            err_d = 1'b1;
          end else begin
            end_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign addr       = addr_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign pkt_start  = start_q;
  assign pkt_end    = end_q;
  assign pkt_err    = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_packet_dispatcher.sv
// tb_uart_packet_dispatcher: scoreboard bench, two DUTs (CHECK_CRC 0 and 1)
// both with TIMEOUT_CLKS=100, fed the same byte stream
module tb_uart_packet_dispatcher;

  logic       clk;
  logic       n_rst;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic [6:0] addr0, addr1;
  logic [7:0] data0, data1;
  logic       dv0, dv1, ps0, ps1, pe0, pe1;
  logic       perr0, perr1, busy0, busy1;

  uart_packet_dispatcher #(
    .CHECK_CRC(1'b0), .TIMEOUT_CLKS(100)
  ) u_dut0 (
    .clk(clk), .n_rst(n_rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .addr(addr0), .data(data0), .data_valid(dv0),
    .pkt_start(ps0), .pkt_end(pe0), .pkt_err(perr0),
    .busy(busy0)
  );

  uart_packet_dispatcher #(
    .CHECK_CRC(1'b1), .TIMEOUT_CLKS(100)
  ) u_dut1 (
    .clk(clk), .n_rst(n_rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .addr(addr1), .data(data1), .data_valid(dv1),
    .pkt_start(ps1), .pkt_end(pe1), .pkt_err(perr1),
    .busy(busy1)
  );

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  exp_t  q0[$];
  exp_t  q1[$];
  int    cyc;
  int    last_cyc;
  int    last_err0, last_err1;
  int    n_ev[6];
  int    exp_ev[6];
  string ev_nm[6] = '{"start0", "end0", "err0",
                      "start1", "end1", "err1"};
  logic [6:0] exp_addr;
  int    checks;
  int    errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (n_rst) begin
      if (dv0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL dv0_unexpected: data=%h cyc=%0d", data0, cyc);
        end else begin
          exp_t e;
          e = q0.pop_front();
          if (data0 !== e.b || cyc !== e.c) begin
            errors++;
            $display("FAIL dv0: got %h@%0d want %h@%0d",
                     data0, cyc, e.b, e.c);
          end
        end
      end
      if (dv1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL dv1_unexpected: data=%h cyc=%0d", data1, cyc);
        end else begin
          exp_t e;
          e = q1.pop_front();
          if (data1 !== e.b || cyc !== e.c) begin
            errors++;
            $display("FAIL dv1: got %h@%0d want %h@%0d",
                     data1, cyc, e.b, e.c);
          end
        end
      end
      if (ps0) n_ev[0]++;
      if (pe0) n_ev[1]++;
      if (perr0) begin n_ev[2]++; last_err0 = cyc; end
      if (ps1) n_ev[3]++;
      if (pe1) n_ev[4]++;
      if (perr1) begin n_ev[5]++; last_err1 = cyc; end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit fwd,
                           input int gap);
    exp_t e;
    rx_data  = b;
    rx_valid = 1'b1;
    last_cyc = cyc + 1;
    if (fwd) begin
      e.b = b;
      e.c = cyc + 1;
      q0.push_back(e);
      q1.push_back(e);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] pl[$],
                            input logic [7:0] crc, input int gap);
    logic [7:0] len;
    logic [7:0] x;
    bit drop;
    len  = 8'(pl.size());
    drop = a[7];
    x    = a ^ len;
    foreach (pl[i]) x = x ^ pl[i];
    send_byte(8'hEE, 1'b0, gap);
    send_byte(a, 1'b0, gap);
    send_byte(len, 1'b0, gap);
    foreach (pl[i]) send_byte(pl[i], !drop, gap);
    send_byte(crc, 1'b0, gap);
    if (!drop) begin
      exp_addr = a[6:0];
      exp_ev[0]++;
      exp_ev[3]++;
      exp_ev[1]++;
      if (crc == x) exp_ev[4]++;
      else exp_ev[5]++;
    end else begin
      exp_ev[2]++;
      exp_ev[5]++;
    end
  endtask

  task automatic test_reset;
    n_rst    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    checks++;
    if ({addr0, data0, dv0, ps0, pe0, perr0, busy0} !== 20'h0) begin
      errors++;
      $display("FAIL reset0: got %h want 0",
               {addr0, data0, dv0, ps0, pe0, perr0, busy0});
    end
    checks++;
    if ({addr1, data1, dv1, ps1, pe1, perr1, busy1} !== 20'h0) begin
      errors++;
      $display("FAIL reset1: got %h want 0",
               {addr1, data1, dv1, ps1, pe1, perr1, busy1});
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] pl[$];
    pl = '{8'h16, 8'h1D};
    send_frame(8'h09, pl, 8'hCC, 1);
    send_frame(8'h09, pl, 8'h00, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (addr0 !== 7'h09 || addr1 !== 7'h09) begin
      errors++;
      $display("FAIL basic_addr: got %h/%h want 09", addr0, addr1);
    end
    checks++;
    if (data0 !== 8'h1D) begin
      errors++;
      $display("FAIL basic_data_hold: got %h want 1d", data0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (n_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL basic_%s: got %0d want %0d",
                 ev_nm[i], n_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_long_payload;
    logic [7:0] pl[$];
    pl = '{8'hA0, 8'h02, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(8'h29, pl, 8'hCC, 1);
    pl = '{8'hEE};
    send_frame(8'h29, pl, 8'hC6, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (addr0 !== 7'h29 || data1 !== 8'hEE) begin
      errors++;
      $display("FAIL long_addr_data: got %h/%h want 29/ee", addr0, data1);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (n_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL long_%s: got %0d want %0d",
                 ev_nm[i], n_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_garbage_len0;
    logic [7:0] pl[$];
    send_byte(8'h55, 1'b0, 1);
    send_byte(8'hAA, 1'b0, 1);
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL garbage_busy: got %b/%b want 0", busy0, busy1);
    end
    send_byte(8'hEE, 1'b0, 0);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL prefix_busy: got %b want 1", busy0);
    end
    send_byte(8'h00, 1'b0, 1);
    send_byte(8'h01, 1'b0, 1);
    send_byte(8'hAE, 1'b1, 1);
    send_byte(8'hCC, 1'b0, 1);
    exp_addr = 7'h00;
    exp_ev[0]++; exp_ev[3]++; exp_ev[1]++; exp_ev[5]++;
    pl = {};
    send_frame(8'h18, pl, 8'hCC, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (addr0 !== 7'h18) begin
      errors++;
      $display("FAIL len0_addr: got %h want 18", addr0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (n_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL garbage_%s: got %0d want %0d",
                 ev_nm[i], n_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_timeout;
    int a0;
    logic [7:0] pl[$];
    send_byte(8'hEE, 1'b0, 1);
    send_byte(8'h0A, 1'b0, 1);
    send_byte(8'h02, 1'b0, 1);
    send_byte(8'hA0, 1'b1, 0);
    a0 = last_cyc;
    exp_addr = 7'h0A;
    exp_ev[0]++; exp_ev[3]++; exp_ev[2]++; exp_ev[5]++;
    repeat (150) @(negedge clk);
    checks++;
    if (last_err0 !== a0 + 100 || last_err1 !== a0 + 100) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d/%0d want %0d",
               last_err0, last_err1, a0 + 100);
    end
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: got %b/%b want 0", busy0, busy1);
    end
    pl = '{8'h16, 8'h1D};
    send_frame(8'h09, pl, 8'h00, 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (n_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL timeout_%s: got %0d want %0d",
                 ev_nm[i], n_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_bad_addr;
    logic [7:0] pl[$];
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h85, pl, 8'h00, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (addr0 !== 7'h09 || addr1 !== 7'h09) begin
      errors++;
      $display("FAIL badaddr_hold: got %h/%h want 09", addr0, addr1);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (n_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL badaddr_%s: got %0d want %0d",
                 ev_nm[i], n_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pl[$];
    pl = '{8'h5A};
    send_frame(8'h31, pl, 8'h6A, 0);
    pl = '{8'h01, 8'h02, 8'h03};
    send_frame(8'h32, pl, 8'h03, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (addr1 !== 7'h32 || data0 !== 8'h03) begin
      errors++;
      $display("FAIL b2b_addr_data: got %h/%h want 32/03", addr1, data0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (n_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL b2b_%s: got %0d want %0d",
                 ev_nm[i], n_ev[i], exp_ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'hEE, 1'b0, 1);
    send_byte(8'h09, 1'b0, 1);
    send_byte(8'h03, 1'b0, 1);
    send_byte(8'h11, 1'b1, 1);
    exp_ev[0]++; exp_ev[3]++;
    checks++;
    if (busy0 !== 1'b1 || data0 !== 8'h11) begin
      errors++;
      $display("FAIL midframe_pre: got %b/%h want 1/11", busy0, data0);
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({addr0, data0, dv0, ps0, pe0, perr0, busy0} !== 20'h0 ||
        {addr1, data1, dv1, ps1, pe1, perr1, busy1} !== 20'h0) begin
      errors++;
      $display("FAIL midframe_reset: got %h/%h want 0",
               {addr0, data0, dv0, ps0, pe0, perr0, busy0},
               {addr1, data1, dv1, ps1, pe1, perr1, busy1});
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (q0.size() !== 0 || q1.size() !== 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d/%0d want 0", q0.size(), q1.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (n_ev[i] !== exp_ev[i]) begin
        errors++;
        $display("FAIL midframe_%s: got %0d want %0d",
                 ev_nm[i], n_ev[i], exp_ev[i]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    last_cyc = 0;
    exp_addr = 7'h00;
    for (int i = 0; i < 6; i++) begin
      n_ev[i]   = 0;
      exp_ev[i] = 0;
    end
    test_reset();
    test_basic();
    test_long_payload();
    test_garbage_len0();
    test_timeout();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
